// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue FSM driving the combinational ALU
// Operand A always comes from the accumulator; every command produces exactly one tagged response.
module alu_cmd_sequencer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             alu_valid,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [3:0]       rsp_tag,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] K_EXEC  = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_PEEK  = 2'b10;
  localparam logic [1:0] K_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]       fifo_kind [DEPTH];
  logic [3:0]       fifo_op   [DEPTH];
  logic [WIDTH-1:0] fifo_b    [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       tag_cnt;

  logic             push, pop, fifo_empty;
  logic [1:0]       head_kind;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_b;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign head_kind  = fifo_kind[rd_ptr];
  assign head_op    = fifo_op[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign busy       = !fifo_empty || (state != IDLE);
  assign rsp_tag    = tag_cnt;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_kind[wr_ptr] <= cmd_kind;
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_b[wr_ptr]    <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = (head_kind == K_EXEC) ? ISSUE : RESP;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      tag_cnt   <= '0;
      alu_valid <= 1'b0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            case (head_kind)
              K_EXEC: begin
                alu_ctrl  <= head_op;
                alu_a     <= acc;
                alu_b     <= head_b;
                alu_valid <= 1'b1;
              end
              K_LOAD: begin
                acc       <= head_b;
                rsp_data  <= head_b;
                rsp_carry <= 1'b0;
                rsp_zero  <= (head_b == '0);
                rsp_valid <= 1'b1;
              end
              K_PEEK: begin
                rsp_data  <= acc;
                rsp_carry <= 1'b0;
                rsp_zero  <= (acc == '0);
                rsp_valid <= 1'b1;
              end
              K_CLEAR: begin
                acc       <= '0;
                rsp_data  <= '0;
                rsp_carry <= 1'b0;
                rsp_zero  <= 1'b1;
                rsp_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ISSUE: begin
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
          rsp_zero  <= alu_zero;
          acc       <= alu_out;
          alu_valid <= 1'b0;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            tag_cnt   <= tag_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
